// File: rtl/rd_fifo_w128r16_pkg.sv
// Shared widths, lane geometry and flag-threshold defaults for the 128-in / 16-out FIFO.
// Optional build macro used by the top: RD_FIFO_W128R16_OUTPUT_REG_EN.
package rd_fifo_w128r16_pkg;

  localparam int WR_DEPTH_W       = 10;
  localparam int WR_DATA_W        = 128;
  localparam int RD_DEPTH_W       = 13;
  localparam int RD_DATA_W        = 16;
  localparam int RATIO            = WR_DATA_W / RD_DATA_W;
  localparam int LANE_W           = $clog2(RATIO);
  localparam int ALMOST_FULL_DEF  = 252;
  localparam int ALMOST_EMPTY_DEF = 4;

  typedef logic [WR_DATA_W-1:0]  wr_word_t;
  typedef logic [RD_DATA_W-1:0]  rd_word_t;
  typedef logic [WR_DEPTH_W:0]   wr_lvl_t;
  typedef logic [RD_DEPTH_W:0]   rd_lvl_t;

endpackage

// File: rtl/rd_fifo_w128r16_if.sv
// Write/read port bundle of the width-converting FIFO; master = producer/consumer, slave = FIFO.
interface rd_fifo_w128r16_if;
  import rd_fifo_w128r16_pkg::*;

  wr_word_t wr_data;
  logic     wr_en;
  logic     wr_full;
  wr_lvl_t  wr_water_level;
  logic     almost_full;
  logic     rd_en;
  rd_word_t rd_data;
  logic     rd_empty;
  rd_lvl_t  rd_water_level;
  logic     almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, almost_full,
    input  rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, almost_full,
    output rd_data, rd_empty, rd_water_level, almost_empty
  );

endinterface

// File: rtl/rd_fifo_w128r16_ram.sv
// Simple dual-port RAM: synchronous write, one-cycle synchronous read that holds when not enabled.
module rd_fifo_w128r16_ram #(
  parameter int AW = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rd_fifo_w128r16.sv
// 128-bit write / 16-bit read single-clock FIFO with levels and almost flags.
// Define RD_FIFO_W128R16_OUTPUT_REG_EN to add an output register on rd_data (2-cycle read latency).
module rd_fifo_w128r16
  import rd_fifo_w128r16_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH   = WR_DEPTH_W,
  parameter int WR_DATA_WIDTH    = WR_DATA_W,
  parameter int RD_DEPTH_WIDTH   = RD_DEPTH_W,
  parameter int RD_DATA_WIDTH    = RD_DATA_W,
  parameter int ALMOST_FULL_NUM  = ALMOST_FULL_DEF,
  parameter int ALMOST_EMPTY_NUM = ALMOST_EMPTY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  rd_fifo_w128r16_if.slave bus
);

  localparam logic [WR_DEPTH_WIDTH:0] AF_TH = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
  localparam logic [RD_DEPTH_WIDTH:0] AE_TH = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

  logic [WR_DEPTH_WIDTH:0] wr_ptr_q, wr_ptr_d, wr_lvl;
  logic [RD_DEPTH_WIDTH:0] rd_ptr_q, rd_ptr_d, rd_lvl;
  logic                    wr_full, rd_empty, wr_acc, rd_acc;
  logic [LANE_W-1:0]       lane_q;
  logic                    seen_q;
  logic [WR_DATA_WIDTH-1:0] ram_rd;
  logic [RD_DATA_WIDTH-1:0] lane_data, stage1;

  // A slot stays occupied until its last lane is read, hence the word-granular rd_ptr slice.
  assign wr_lvl   = wr_ptr_q - rd_ptr_q[RD_DEPTH_WIDTH:LANE_W];
  assign rd_lvl   = {wr_ptr_q, {LANE_W{1'b0}}} - rd_ptr_q;
  assign wr_full  = wr_lvl[WR_DEPTH_WIDTH];
  assign rd_empty = (rd_lvl == '0);
  assign wr_acc   = bus.wr_en & ~wr_full;
  assign rd_acc   = bus.rd_en & ~rd_empty;
  assign wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seen_q   <= seen_q | rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) lane_q <= rd_ptr_q[LANE_W-1:0];
  end

  rd_fifo_w128r16_ram #(
    .AW(WR_DEPTH_WIDTH),
    .DW(WR_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[WR_DEPTH_WIDTH-1:0]),
    .wdata_i (bus.wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[RD_DEPTH_WIDTH-1:LANE_W]),
    .rdata_o (ram_rd)
  );

  // ---- stage 1: RAM word + registered lane select
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == i[LANE_W-1:0]) lane_data = ram_rd[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
  end

  // RAM output is not reset, so rd_data reads as zero until the first read after reset.
  assign stage1 = seen_q ? lane_data : '0;

`ifdef RD_FIFO_W128R16_OUTPUT_REG_EN
  // ---- stage 2: optional output register
  logic [RD_DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= stage1;
  end

  assign bus.rd_data = rd_data_q;
`else
  assign bus.rd_data = stage1;
`endif

  assign bus.wr_full        = wr_full;
  assign bus.wr_water_level = wr_lvl;
  assign bus.almost_full    = (wr_lvl >= AF_TH);
  assign bus.rd_empty       = rd_empty;
  assign bus.rd_water_level = rd_lvl;
  assign bus.almost_empty   = (rd_lvl <= AE_TH);

endmodule

// File: tb/tb_rd_fifo_w128r16.sv
// Self-checking bench for rd_fifo_w128r16: queue-of-lanes reference model plus directed and random phases.
module tb_rd_fifo_w128r16;
  import rd_fifo_w128r16_pkg::*;

`ifdef RD_FIFO_W128R16_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rd_fifo_w128r16_if bus();

  rd_fifo_w128r16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: readable 16-bit words in order, plus the history of the read data path.
  logic [15:0]  mq[$];
  logic [15:0]  exp_hist[2];
  int           vectors     = 0;
  int           miscompares = 0;
  bit           chk_en      = 1'b0;
  logic [127:0] data;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  function automatic int m_rdlvl();
    return mq.size();
  endfunction

  function automatic int m_wrlvl();
    return (mq.size() + 7) / 8;
  endfunction

  function automatic void model_apply(logic r, logic we, logic [127:0] wd, logic re);
    bit racc, wacc;
    if (r) begin
      mq.delete();
      exp_hist[0] = '0;
      exp_hist[1] = '0;
      return;
    end
    racc = re && (mq.size() != 0);
    wacc = we && (m_wrlvl() < 1024);
    exp_hist[1] = exp_hist[0];
    if (racc) exp_hist[0] = mq.pop_front();
    if (wacc) for (int k = 0; k < 8; k++) mq.push_back(wd[16*k +: 16]);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_apply(rst, bus.wr_en, bus.wr_data, bus.rd_en);
    #1;
  endtask

  task automatic drive(logic we, logic [127:0] wd, logic re);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    tick();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data",        128'(bus.rd_data),        128'(exp_hist[LAT-1]));
      chk("wr_water_level", 128'(bus.wr_water_level), 128'(m_wrlvl()));
      chk("rd_water_level", 128'(bus.rd_water_level), 128'(m_rdlvl()));
      chk("wr_full",        128'(bus.wr_full),        128'(m_wrlvl() == 1024));
      chk("rd_empty",       128'(bus.rd_empty),       128'(m_rdlvl() == 0));
      chk("almost_full",    128'(bus.almost_full),    128'(m_wrlvl() >= 252));
      chk("almost_empty",   128'(bus.almost_empty),   128'(m_rdlvl() <= 4));
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rd_empty"},     128'(bus.rd_empty),       128'(1));
    chk({tag, "_almost_empty"}, 128'(bus.almost_empty),   128'(1));
    chk({tag, "_wr_full"},      128'(bus.wr_full),        128'(0));
    chk({tag, "_almost_full"},  128'(bus.almost_full),    128'(0));
    chk({tag, "_wr_lvl"},       128'(bus.wr_water_level), 128'(0));
    chk({tag, "_rd_lvl"},       128'(bus.rd_water_level), 128'(0));
    chk({tag, "_rd_data"},      128'(bus.rd_data),        128'(0));
  endtask

  initial begin
    logic [127:0] pd;
    int wp, rp;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    exp_hist[0] = '0;
    exp_hist[1] = '0;

    // Reset held for two clocks
    tick();
    chk_en = 1'b1;
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Fill with decrementing all-ones words, one past capacity
    data = '1;
    for (int k = 1; k <= 1025; k++) begin
      drive(1'b1, data, 1'b0);
      data = data - 1'b1;
      if (k == 251)  chk("af_at_251",   128'(bus.almost_full), 128'(0));
      if (k == 252)  chk("af_at_252",   128'(bus.almost_full), 128'(1));
      if (k == 1023) chk("full_at_1023", 128'(bus.wr_full),    128'(0));
      if (k == 1024) chk("full_at_1024", 128'(bus.wr_full),    128'(1));
    end
    chk("fill_wr_lvl", 128'(bus.wr_water_level), 128'(1024));
    chk("fill_rd_lvl", 128'(bus.rd_water_level), 128'(8192));

    // Drain one past empty; idle cycles let either latency settle before literal data checks
    for (int k = 1; k <= 8193; k++) begin
      drive(1'b0, '0, 1'b1);
      if (k == 8187) chk("ae_at_lvl5",  128'(bus.almost_empty), 128'(0));
      if (k == 8188) chk("ae_at_lvl4",  128'(bus.almost_empty), 128'(1));
      if (k == 8191) chk("empty_8191",  128'(bus.rd_empty),     128'(0));
      if (k == 8192) chk("empty_8192",  128'(bus.rd_empty),     128'(1));
      if (k == 1 || k == 9 || k == 10 || k == 8185 || k == 8193) begin
        drive(1'b0, '0, 1'b0);
        if (k == 1)    chk("drain_w0_l0",   128'(bus.rd_data), 128'(16'hFFFF));
        if (k == 9)    chk("drain_w1_l0",   128'(bus.rd_data), 128'(16'hFFFE));
        if (k == 10)   chk("drain_w1_l1",   128'(bus.rd_data), 128'(16'hFFFF));
        if (k == 8185) chk("drain_last_l0", 128'(bus.rd_data), 128'(16'hFC00));
        if (k == 8193) chk("drain_hold",    128'(bus.rd_data), 128'(16'hFFFF));
      end
    end
    chk("drain_rd_lvl", 128'(bus.rd_water_level), 128'(0));

    // Partial read of one word keeps its slot occupied
    pd = rnd128();
    drive(1'b1, pd, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1);
    chk("part_wr_lvl", 128'(bus.wr_water_level), 128'(1));
    chk("part_rd_lvl", 128'(bus.rd_water_level), 128'(5));
    for (int k = 0; k < 5; k++) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    chk("part_wr_lvl0", 128'(bus.wr_water_level), 128'(0));
    chk("part_rd_lvl0", 128'(bus.rd_water_level), 128'(0));
    chk("part_last",    128'(bus.rd_data),        128'(pd[127:112]));

    // Concurrent write and read every cycle from 8 words
    for (int k = 0; k < 8; k++) drive(1'b1, rnd128(), 1'b0);
    for (int k = 0; k < 100; k++) drive(1'b1, rnd128(), 1'b1);
    chk("conc_rd_lvl", 128'(bus.rd_water_level), 128'(764));
    chk("conc_wr_lvl", 128'(bus.wr_water_level), 128'(96));

    // Reset in the middle of the stream
    rst = 1'b1;
    drive(1'b1, rnd128(), 1'b1);
    rst = 1'b0;
    chk_reset_vals("midrst");

    // Random phases: fill toward full, drain toward empty, then balanced with rare resets
    for (int ph = 0; ph < 3; ph++) begin
      int n;
      n  = (ph == 0) ? 2500 : (ph == 1) ? 11000 : 4000;
      wp = (ph == 0) ? 60   : (ph == 1) ? 2     : 12;
      rp = (ph == 0) ? 90   : (ph == 1) ? 95    : 95;
      for (int k = 0; k < n; k++) begin
        rst = (ph == 2) && ($urandom_range(0, 1999) == 0);
        drive(1'($urandom_range(0, 99) < wp), rnd128(), 1'($urandom_range(0, 99) < rp));
      end
      rst = 1'b0;
    end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
